conv_ram_reader: RTL and testbench

CONV_RAM_READER -- requirements
Module: conv_ram_reader

---
 rtl/conv_pkg.sv | 18 +
 rtl/conv_rdr_fifo.sv | 66 ++++++
 rtl/conv_ram_reader.sv | 132 +++++++++++++
 tb/tb_conv_ram_reader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and FSM state encoding for the Conv RAM reader.
// Default frame geometry is 8x8 pixels, 8-bit pixels, 64-entry RAM.
package conv_pkg;

    localparam int IMG_DIM    = 8;
    localparam int PIX_W      = 8;
    localparam int ADDR_W     = 6;
    localparam int FIFO_DEPTH = 3;
    localparam int CNT_W      = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/conv_rdr_fifo.sv
// Three-entry shift-register FIFO. The head is always entry 0, so the
// outputs it drives come straight from flops.
module conv_rdr_fifo
    import conv_pkg::*;
#(
    parameter int W = PIX_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [W-1:0]     mem [0:FIFO_DEPTH-1];
    logic [CNT_W-1:0] wr_idx;
    logic [CNT_W-1:0] count_next;

    // Write slot and occupancy; a simultaneous pop shifts the slot down by one.
    always_comb begin
        wr_idx     = count;
        count_next = count;
        if (pop) begin
            wr_idx = count - CNT_ONE;
        end else begin
            wr_idx = count;
        end
        case ({push, pop})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    // Storage: slots at or above count are kept at zero, so an empty FIFO shows zero at its head.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            count <= count_next;
            if (pop) begin
                for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                    mem[i] <= mem[i+1];
                end
                mem[FIFO_DEPTH-1] <= '0;
            end
            if (push) begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    if (CNT_W'(i) == wr_idx) begin
                        mem[i] <= push_data;
                    end
                end
            end
        end
    end

    assign head = mem[0];

endmodule

// File: rtl/conv_ram_reader.sv
// Streams one IMG_DIM x IMG_DIM frame from RAM to the Conv stage in raster order.
// Optional pixel checksum output pix_sum is enabled by defining CONV_RDR_CHECKSUM_EN.
module conv_ram_reader
    import conv_pkg::*;
#(
    parameter int IMG_DIM = conv_pkg::IMG_DIM,
    parameter int PIX_W   = conv_pkg::PIX_W,
    parameter int ADDR_W  = conv_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [PIX_W-1:0]  ram_dout,
    output logic              out_st,
    output logic [PIX_W-1:0]  dout,
    output logic              out_last,
    input  logic              ready,
    output logic              busy,
    output logic              done
`ifdef CONV_RDR_CHECKSUM_EN
    ,
    output logic [13:0]       pix_sum
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_DIM * IMG_DIM - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [2:0]        DEPTH3    = 3'(FIFO_DEPTH);

    state_t           state;
    logic             inflight;
    logic             inflight_last;
    logic             pop;
    logic             can_issue;
    logic             last_issued;
    logic [CNT_W-1:0] fifo_count;
    logic [PIX_W:0]   head;
    logic [2:0]       occupancy;

    conv_rdr_fifo #(
        .W (PIX_W + 1)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data ({inflight_last, ram_dout}),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    assign out_st   = (fifo_count != '0);
    assign dout     = head[PIX_W-1:0];
    assign out_last = head[PIX_W];
    assign pop      = out_st & ready;
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

    // Slots claimed after this edge: stored pixels, read on the bus, data landing now,
    // less the pixel leaving now. Counting the pop keeps one read per cycle at full rate.
    always_comb begin
        occupancy   = {1'b0, fifo_count} + {2'b00, ram_rd} + {2'b00, inflight} - {2'b00, pop};
        can_issue   = (occupancy < DEPTH3);
        last_issued = (ram_addr == LAST_ADDR);
    end

    // Frame FSM and read issue; ram_addr always holds the most recently issued address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            ram_rd        <= 1'b0;
            ram_addr      <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= ram_rd;
            inflight_last <= ram_rd & last_issued;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_FETCH;
                        ram_rd   <= 1'b1;
                        ram_addr <= '0;
                    end else begin
                        ram_rd <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (last_issued) begin
                        state  <= ST_DRAIN;
                        ram_rd <= 1'b0;
                    end else if (can_issue) begin
                        ram_rd   <= 1'b1;
                        ram_addr <= ram_addr + ADDR_ONE;
                    end else begin
                        ram_rd <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    ram_rd <= 1'b0;
                    if (pop && out_last) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ram_rd <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    ram_rd <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CONV_RDR_CHECKSUM_EN
    // Running sum of accepted pixels, held after done until the next accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_sum <= 14'd0;
        end else if ((state == ST_IDLE) && start) begin
            pix_sum <= 14'd0;
        end else if (pop) begin
            pix_sum <= pix_sum + 14'(dout);
        end
    end
`endif

endmodule

// File: tb/tb_conv_ram_reader.sv
// Directed self-checking bench for conv_ram_reader; covers the checksum
// output too when CONV_RDR_CHECKSUM_EN is defined.
module tb_conv_ram_reader;

    localparam int PIX_W  = 8;
    localparam int ADDR_W = 6;
    localparam int NPIX   = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              ready;
    logic              ram_rd;
    logic [ADDR_W-1:0] ram_addr;
    logic [PIX_W-1:0]  ram_dout;
    logic              out_st;
    logic [PIX_W-1:0]  dout;
    logic              out_last;
    logic              busy;
    logic              done;
`ifdef CONV_RDR_CHECKSUM_EN
    logic [13:0]       pix_sum;
`endif

    logic [PIX_W-1:0] mem [0:NPIX-1];

    int n_pass  = 0;
    int n_total = 0;

    int fr_accepted, fr_order_err, fr_last_err, fr_hold_err, fr_addr_err;
    int fr_max_out, fr_done_cnt, fr_done_gap, fr_done_acc, fr_busy_after;

    always #5 clk = ~clk;

    always @(posedge clk) ram_dout <= mem[ram_addr];

    conv_ram_reader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .ram_rd   (ram_rd),
        .ram_addr (ram_addr),
        .ram_dout (ram_dout),
        .out_st   (out_st),
        .dout     (dout),
        .out_last (out_last),
        .ready    (ready),
        .busy     (busy),
        .done     (done)
`ifdef CONV_RDR_CHECKSUM_EN
        ,
        .pix_sum  (pix_sum)
`endif
    );

    // Runs one frame from the current negedge (cycle 0 = start cycle) and records what it saw.
    // mode 0: ready high; 1: ready low in cycles 5..14; 2: ready high on odd cycles only.
    task automatic drive_frame(input int mode, input int restart_at);
        int exp_idx = 0;
        int issued = 0;
        int last_acc = -100;
        int done_k = -1;
        logic prev_hold = 1'b0;
        logic [PIX_W-1:0] prev_dout = '0;
        logic prev_last = 1'b0;
        fr_accepted = 0; fr_order_err = 0; fr_last_err = 0; fr_hold_err = 0;
        fr_addr_err = 0; fr_max_out = 0; fr_done_cnt = 0; fr_done_gap = -1;
        fr_done_acc = -1; fr_busy_after = 0;
        start = 1'b1;
        ready = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            start = (k == restart_at);
            case (mode)
                1:       ready = !(k >= 5 && k <= 14);
                2:       ready = (k % 2 == 1);
                default: ready = 1'b1;
            endcase
            if (prev_hold && (!out_st || dout !== prev_dout || out_last !== prev_last))
                fr_hold_err++;
            if (ram_rd === 1'b1) begin
                if (int'(ram_addr) != issued) fr_addr_err++;
                issued++;
            end
            if (issued - fr_accepted > fr_max_out) fr_max_out = issued - fr_accepted;
            if (done_k >= 0 && busy !== 1'b0) fr_busy_after = 1;
            if (done === 1'b1) begin
                fr_done_cnt++;
                fr_done_gap = k - last_acc;
                fr_done_acc = fr_accepted;
                if (done_k < 0) done_k = k;
            end
            if (out_st === 1'b1 && ready) begin
                if (exp_idx >= NPIX || dout !== mem[exp_idx]) fr_order_err++;
                if (out_last !== (exp_idx == NPIX - 1)) fr_last_err++;
                exp_idx++;
                fr_accepted++;
                last_acc = k;
            end
            prev_hold = out_st && !ready;
            prev_dout = dout;
            prev_last = out_last;
            if (done_k >= 0 && k >= done_k + 4) break;
        end
        start = 1'b0;
        ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; ready = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if ({ram_rd, ram_addr, out_st, dout, out_last, busy, done} !== '0)
            $display("FAIL reset_outputs: got %h expected 0",
                     {ram_rd, ram_addr, out_st, dout, out_last, busy, done});
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if ({ram_rd, busy, out_st} !== 3'b000)
            $display("FAIL idle_after_reset: got %b expected 000", {ram_rd, busy, out_st});
        else n_pass++;
    endtask

    // Exact cycle timing with ready held high; start in cycle 0.
    task automatic test_basic();
        logic [4:0] exp_v;
        start = 1'b1; ready = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            start = 1'b0;
            exp_v = {k <= 64, k >= 3 && k <= 66, k == 66, k >= 1 && k <= 67, k == 67};
            n_total++;
            if ({ram_rd, out_st, out_last, busy, done} !== exp_v)
                $display("FAIL basic_ctrl cycle %0d: got %b expected %b (rd,st,last,busy,done)",
                         k, {ram_rd, out_st, out_last, busy, done}, exp_v);
            else n_pass++;
            if (k >= 3 && k <= 66) begin
                n_total++;
                if (dout !== PIX_W'(k - 3))
                    $display("FAIL basic_dout cycle %0d: got %0d expected %0d", k, dout, k - 3);
                else n_pass++;
            end
            if (k <= 64) begin
                n_total++;
                if (ram_addr !== ADDR_W'(k - 1))
                    $display("FAIL basic_addr cycle %0d: got %0d expected %0d", k, ram_addr, k - 1);
                else n_pass++;
            end
        end
    endtask

    task automatic test_ready_stall();
        drive_frame(1, 0);
        n_total++;
        if (fr_max_out > 3) $display("FAIL stall_outstanding: got %0d expected <=3", fr_max_out);
        else n_pass++;
        n_total++;
        if (fr_hold_err != 0) $display("FAIL stall_hold: got %0d expected 0", fr_hold_err);
        else n_pass++;
        n_total++;
        if (fr_accepted != 64 || fr_order_err != 0)
            $display("FAIL stall_sequence: got %0d pixels %0d errors expected 64 pixels 0 errors",
                     fr_accepted, fr_order_err);
        else n_pass++;
        n_total++;
        if (fr_done_cnt != 1) $display("FAIL stall_done: got %0d expected 1", fr_done_cnt);
        else n_pass++;
    endtask

    task automatic test_ready_toggle();
        drive_frame(2, 0);
        n_total++;
        if (fr_accepted != 64 || fr_order_err != 0 || fr_last_err != 0)
            $display("FAIL toggle_sequence: got %0d pixels %0d/%0d errors expected 64 0/0",
                     fr_accepted, fr_order_err, fr_last_err);
        else n_pass++;
        n_total++;
        if (fr_hold_err != 0) $display("FAIL toggle_hold: got %0d expected 0", fr_hold_err);
        else n_pass++;
        n_total++;
        if (fr_done_gap != 1 || fr_done_acc != 64)
            $display("FAIL toggle_done: got gap %0d after %0d pixels expected gap 1 after 64",
                     fr_done_gap, fr_done_acc);
        else n_pass++;
    endtask

    // Starts issued while busy and while in DONE, then an immediate fresh frame.
    task automatic test_back_to_back();
        drive_frame(0, 20);
        n_total++;
        if (fr_accepted != 64 || fr_done_cnt != 1 || fr_addr_err != 0)
            $display("FAIL restart_busy: got %0d pixels %0d done %0d addr errors expected 64 1 0",
                     fr_accepted, fr_done_cnt, fr_addr_err);
        else n_pass++;
        drive_frame(0, 67);
        n_total++;
        if (fr_busy_after != 0 || fr_done_cnt != 1)
            $display("FAIL restart_done: got busy_after %0d done %0d expected 0 1",
                     fr_busy_after, fr_done_cnt);
        else n_pass++;
        drive_frame(0, 0);
        n_total++;
        if (fr_addr_err != 0 || fr_accepted != 64 || fr_last_err != 0)
            $display("FAIL second_frame: got %0d addr errors %0d pixels expected 0 64",
                     fr_addr_err, fr_accepted);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        int bad = 0;
        start = 1'b1; ready = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 30) rst_n = 1'b0;
        end
        n_total++;
        if (busy !== 1'b1) $display("FAIL midframe_busy: got %b expected 1", busy);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        n_total++;
        if ({ram_rd, ram_addr, out_st, dout, out_last, busy, done} !== '0)
            $display("FAIL midframe_reset: got %h expected 0",
                     {ram_rd, ram_addr, out_st, dout, out_last, busy, done});
        else n_pass++;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_st !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL midframe_quiet: got %0d bad cycles expected 0", bad);
        else n_pass++;
        drive_frame(0, 0);
        n_total++;
        if (fr_addr_err != 0 || fr_accepted != 64 || fr_done_cnt != 1)
            $display("FAIL after_reset_frame: got %0d addr errors %0d pixels %0d done expected 0 64 1",
                     fr_addr_err, fr_accepted, fr_done_cnt);
        else n_pass++;
    endtask

`ifdef CONV_RDR_CHECKSUM_EN
    task automatic test_checksum();
        int exp_sum = 0;
        for (int i = 0; i < NPIX; i++) begin
            mem[i] = PIX_W'((((i * 37 + 11) % 256) * 128) / 255);
            exp_sum += int'(mem[i]);
        end
        drive_frame(0, 0);
        n_total++;
        if (int'(pix_sum) != exp_sum) $display("FAIL checksum: got %0d expected %0d", pix_sum, exp_sum);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_total++;
        if (int'(pix_sum) != exp_sum) $display("FAIL checksum_hold: got %0d expected %0d", pix_sum, exp_sum);
        else n_pass++;
    endtask
`endif

    initial begin
        for (int i = 0; i < NPIX; i++) mem[i] = PIX_W'(i);
        test_reset();
        test_basic();
        test_ready_stall();
        test_ready_toggle();
        test_back_to_back();
        test_reset_midframe();
`ifdef CONV_RDR_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
